// File: rtl/beam_threshold_loader_pkg.sv
// Shared constants and sizing helpers for the beam threshold loader.
// NBEAMS beams are carried as dual-beam pairs over two serial lanes; each lane
// receives a (delta, trig) pair per dual beam, so a full load is DEPTH writes.
package beam_threshold_loader_pkg;

  localparam int unsigned DefaultWidth = 18;
  localparam int unsigned NumLanes     = 2;
  localparam int unsigned Lane0        = 0;
  localparam int unsigned Lane1        = 1;

  // Number of dual-beam pairs needed to cover nbeams.
  function automatic int unsigned ndualbeams(input int unsigned nbeams);
    return (nbeams + 1) / 2;
  endfunction

  // Writes per lane for a complete load.
  function automatic int unsigned depth(input int unsigned nbeams);
    return 2 * ndualbeams(nbeams);
  endfunction

  // Write counter width: must hold the saturation value DEPTH+1.
  function automatic int unsigned cnt_width(input int unsigned nbeams);
    return $clog2(depth(nbeams) + 2);
  endfunction

endpackage

// File: rtl/beam_threshold_loader_if.sv
// Threshold update stream bus.
//   thresh        : lane1:lane0 stream data, lane l at [l*WIDTH +: WIDTH]
//   thresh_wr     : per-lane shift strobe
//   thresh_update : per-lane commit strobe
// master drives the stream, slave is the loader.
interface beam_threshold_loader_if
  import beam_threshold_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic [NumLanes*WIDTH-1:0] thresh;
  logic [NumLanes-1:0]       thresh_wr;
  logic [NumLanes-1:0]       thresh_update;

  modport master (
    output thresh,
    output thresh_wr,
    output thresh_update
  );

  modport slave (
    input thresh,
    input thresh_wr,
    input thresh_update
  );

endinterface

// File: rtl/beam_threshold_loader_lane_shadow.sv
// One lane's shadow shift chain plus its active threshold bank.
//   aclk, aresetn : clock, synchronous active-low reset
//   wr_i          : shift strobe, din_i enters slot 0
//   din_i         : lane stream word
//   commit_i      : copy shadow into the active bank
//   trig_o        : active trig per pair, pair k at [k*WIDTH +: WIDTH]
//   delta_o       : active delta per pair, same packing
module beam_threshold_loader_lane_shadow
  import beam_threshold_loader_pkg::*;
#(
  parameter int unsigned       WIDTH        = DefaultWidth,
  parameter int unsigned       NDUAL        = 23,
  parameter logic [WIDTH-1:0]  RESET_THRESH = '1,
  parameter logic [WIDTH-1:0]  RESET_DELTA  = '0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   wr_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   commit_i,
  output logic [NDUAL*WIDTH-1:0] trig_o,
  output logic [NDUAL*WIDTH-1:0] delta_o
);

  localparam int unsigned Depth = 2 * NDUAL;

  logic [WIDTH-1:0] shadow_q [Depth];
  logic [WIDTH-1:0] trig_q   [NDUAL];
  logic [WIDTH-1:0] delta_q  [NDUAL];

  // The stream is sent highest pair first, delta before trig, so after a full
  // load the last word (trig of pair 0) sits in slot 0: even slots hold trig,
  // odd slots hold delta.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < Depth; i++) shadow_q[i] <= '0;
      for (int k = 0; k < NDUAL; k++) begin
        trig_q[k]  <= RESET_THRESH;
        delta_q[k] <= RESET_DELTA;
      end
    end else begin
      if (wr_i) begin
        shadow_q[0] <= din_i;
        for (int i = 1; i < Depth; i++) shadow_q[i] <= shadow_q[i-1];
      end
      if (commit_i) begin
        for (int k = 0; k < NDUAL; k++) begin
          trig_q[k]  <= shadow_q[2*k];
          delta_q[k] <= shadow_q[2*k+1];
        end
      end
    end
  end

  for (genvar k = 0; k < NDUAL; k++) begin : g_pack
    assign trig_o[k*WIDTH +: WIDTH]  = trig_q[k];
    assign delta_o[k*WIDTH +: WIDTH] = delta_q[k];
  end

endmodule

// File: rtl/beam_threshold_loader.sv
// Threshold update stream consumer. Captures the two-lane serial stream into
// shadow chains, checks the lane0 write count on each update strobe and, when
// exactly DEPTH words were loaded, commits the shadow to the active per-beam
// trigger thresholds and deltas.
//   aclk, aresetn  : clock, synchronous active-low reset
//   bus            : stream data / shift strobes / commit strobes (slave)
//   err_clr_i      : clears the sticky error flags
//   trig_thresh_o  : active trigger thresholds, beam b at [b*WIDTH +: WIDTH]
//   delta_o        : active deltas, same packing
//   thresh_valid_o : set by the first successful commit
//   commit_o       : one-cycle pulse when a commit is applied
//   err_count_o    : sticky, a commit was rejected for a bad write count
//   err_lane_o     : sticky, lane0/lane1 strobes disagreed
module beam_threshold_loader
  import beam_threshold_loader_pkg::*;
#(
  parameter int unsigned      NBEAMS       = 46,
  parameter int unsigned      WIDTH        = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_THRESH = '1,
  parameter logic [WIDTH-1:0] RESET_DELTA  = '0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  beam_threshold_loader_if.slave    bus,
  input  logic                      err_clr_i,
  output logic [NBEAMS*WIDTH-1:0]   trig_thresh_o,
  output logic [NBEAMS*WIDTH-1:0]   delta_o,
  output logic                      thresh_valid_o,
  output logic                      commit_o,
  output logic                      err_count_o,
  output logic                      err_lane_o
);

  localparam int unsigned NDual = ndualbeams(NBEAMS);
  localparam int unsigned Depth = depth(NBEAMS);
  localparam int unsigned CntW  = cnt_width(NBEAMS);

  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic            valid_q, valid_d;
  logic            commit_q;
  logic            err_count_q, err_count_d;
  logic            err_lane_q, err_lane_d;

  logic wr0, upd0;
  logic commit_ok, commit_rej, lane_mismatch;

  logic [NDual*WIDTH-1:0] lane_trig  [NumLanes];
  logic [NDual*WIDTH-1:0] lane_delta [NumLanes];

  always_comb begin
    wr0  = bus.thresh_wr[Lane0];
    upd0 = bus.thresh_update[Lane0];

    // A write in the update cycle would shift the chain under the commit.
    commit_ok  = upd0 && (wr_cnt_q == CntW'(Depth)) && !wr0;
    commit_rej = upd0 && !commit_ok;

    lane_mismatch = (bus.thresh_wr[Lane0] != bus.thresh_wr[Lane1]) ||
                    (bus.thresh_update[Lane0] != bus.thresh_update[Lane1]);

    // Any update attempt restarts counting; otherwise count and saturate at
    // Depth+1 so an overfull load can never wrap back to a valid count.
    wr_cnt_d = wr_cnt_q;
    if (upd0) begin
      wr_cnt_d = '0;
    end else if (wr0 && (wr_cnt_q != CntW'(Depth + 1))) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    valid_d = valid_q | commit_ok;

    // A new error outranks a simultaneous clear.
    err_count_d = err_count_q;
    if (err_clr_i)  err_count_d = 1'b0;
    if (commit_rej) err_count_d = 1'b1;

    err_lane_d = err_lane_q;
    if (err_clr_i)     err_lane_d = 1'b0;
    if (lane_mismatch) err_lane_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_cnt_q    <= '0;
      valid_q     <= 1'b0;
      commit_q    <= 1'b0;
      err_count_q <= 1'b0;
      err_lane_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      valid_q     <= valid_d;
      commit_q    <= commit_ok;
      err_count_q <= err_count_d;
      err_lane_q  <= err_lane_d;
    end
  end

  // Both lanes commit on the lane0 decision; each shifts on its own strobe.
  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    beam_threshold_loader_lane_shadow #(
      .WIDTH        (WIDTH),
      .NDUAL        (NDual),
      .RESET_THRESH (RESET_THRESH),
      .RESET_DELTA  (RESET_DELTA)
    ) u_lane (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .wr_i     (bus.thresh_wr[l]),
      .din_i    (bus.thresh[l*WIDTH +: WIDTH]),
      .commit_i (commit_ok),
      .trig_o   (lane_trig[l]),
      .delta_o  (lane_delta[l])
    );
  end

  // Beam 2k comes from lane0 pair k, beam 2k+1 from lane1 pair k.
  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    assign trig_thresh_o[b*WIDTH +: WIDTH] = lane_trig[b % 2][(b / 2)*WIDTH +: WIDTH];
    assign delta_o[b*WIDTH +: WIDTH]       = lane_delta[b % 2][(b / 2)*WIDTH +: WIDTH];
  end

  // With an odd beam count lane1's last pair has no beam to drive.
  if (NBEAMS % 2 != 0) begin : g_odd_tail
    logic unused_lane1_tail;
    assign unused_lane1_tail = ^{lane_trig[Lane1][(NDual-1)*WIDTH +: WIDTH],
                                 lane_delta[Lane1][(NDual-1)*WIDTH +: WIDTH]};
  end

  assign thresh_valid_o = valid_q;
  assign commit_o       = commit_q;
  assign err_count_o    = err_count_q;
  assign err_lane_o     = err_lane_q;

endmodule

// File: tb/tb_beam_threshold_loader.sv
module tb_beam_threshold_loader;

  localparam int W     = 18;
  localparam int NB    = 46;
  localparam int NB45  = 45;
  localparam int ND    = 23;
  localparam int DEPTH = 46;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic aresetn   = 1'b0;
  logic err_clr   = 1'b0;

  beam_threshold_loader_if #(.WIDTH(W)) bus ();

  logic [NB*W-1:0]   trig46, delta46;
  logic [NB45*W-1:0] trig45, delta45;
  logic valid46, commit46, errc46, errl46;
  logic valid45, commit45, errc45, errl45;

  beam_threshold_loader #(.NBEAMS(NB), .WIDTH(W)) dut46 (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .bus            (bus),
    .err_clr_i      (err_clr),
    .trig_thresh_o  (trig46),
    .delta_o        (delta46),
    .thresh_valid_o (valid46),
    .commit_o       (commit46),
    .err_count_o    (errc46),
    .err_lane_o     (errl46)
  );

  beam_threshold_loader #(.NBEAMS(NB45), .WIDTH(W)) dut45 (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .bus            (bus),
    .err_clr_i      (err_clr),
    .trig_thresh_o  (trig45),
    .delta_o        (delta45),
    .thresh_valid_o (valid45),
    .commit_o       (commit45),
    .err_count_o    (errc45),
    .err_lane_o     (errl45)
  );

  // Reference model: per-lane history of the last DEPTH words (oldest first),
  // active beam values, flags, and the count of lane0 writes since last update.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] m_trig  [NB];
  logic [W-1:0] m_delta [NB];
  bit m_valid, m_commit, m_errc, m_errl;
  int m_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [NB*W-1:0] obs, input logic [NB*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [NB*W-1:0] exp_trig_vec();
    logic [NB*W-1:0] v;
    for (int b = 0; b < NB; b++) v[b*W +: W] = m_trig[b];
    return v;
  endfunction

  function automatic logic [NB*W-1:0] exp_delta_vec();
    logic [NB*W-1:0] v;
    for (int b = 0; b < NB; b++) v[b*W +: W] = m_delta[b];
    return v;
  endfunction

  task automatic model_edge(input logic rst_n, input logic [1:0] wr, input logic [1:0] upd,
                            input logic [2*W-1:0] d, input logic clr);
    bit ok;
    int idx;
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        m_trig[b]  = 18'h3FFFF;
        m_delta[b] = 18'h0;
      end
      m_valid = 0; m_commit = 0; m_errc = 0; m_errl = 0; m_cnt = 0;
      q0 = {}; q1 = {};
      for (int i = 0; i < DEPTH; i++) begin
        q0.push_back('0);
        q1.push_back('0);
      end
    end else begin
      ok = upd[0] && (m_cnt == DEPTH) && !wr[0];
      m_commit = ok;
      if (ok) begin
        m_valid = 1;
        // Stream order k = ND-1 downto 0, delta then trig.
        for (int k = 0; k < ND; k++) begin
          idx = 2 * (ND - 1 - k);
          m_delta[2*k]   = q0[idx];
          m_trig[2*k]    = q0[idx+1];
          m_delta[2*k+1] = q1[idx];
          m_trig[2*k+1]  = q1[idx+1];
        end
      end
      if (upd[0] && !ok) m_errc = 1;
      else if (clr)      m_errc = 0;
      if ((wr[0] != wr[1]) || (upd[0] != upd[1])) m_errl = 1;
      else if (clr)                               m_errl = 0;
      if (upd[0])     m_cnt = 0;
      else if (wr[0]) m_cnt = (m_cnt + 1 > DEPTH + 1) ? DEPTH + 1 : m_cnt + 1;
      if (wr[0]) begin q0.push_back(d[W-1:0]);   void'(q0.pop_front()); end
      if (wr[1]) begin q1.push_back(d[2*W-1:W]); void'(q1.pop_front()); end
    end
  endtask

  task automatic step(input logic rst_n, input logic [1:0] wr, input logic [1:0] upd,
                      input logic [2*W-1:0] d, input logic clr);
    aresetn           = rst_n;
    bus.thresh_wr     = wr;
    bus.thresh_update = upd;
    bus.thresh        = d;
    err_clr           = clr;
    @(posedge aclk);
    model_edge(rst_n, wr, upd, d, clr);
    #1;
    cyc++;
    chk("commit46", commit46, m_commit);
    chk("valid46",  valid46,  m_valid);
    chk("errc46",   errc46,   m_errc);
    chk("errl46",   errl46,   m_errl);
    chk("trig46",   trig46,   exp_trig_vec());
    chk("delta46",  delta46,  exp_delta_vec());
    chk("commit45", commit45, m_commit);
    chk("valid45",  valid45,  m_valid);
    chk("errc45",   errc45,   m_errc);
    chk("errl45",   errl45,   m_errl);
    chk("trig45",   trig45,   exp_trig_vec() & {{W{1'b0}}, {NB45*W{1'b1}}});
    chk("delta45",  delta45,  exp_delta_vec() & {{W{1'b0}}, {NB45*W{1'b1}}});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b00, 2'b00, '0, 1'b0);
  endtask

  task automatic rand_writes(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b11, 2'b00, {W'($urandom), W'($urandom)}, 1'b0);
  endtask

  task automatic update();
    step(1'b1, 2'b00, 2'b11, '0, 1'b0);
  endtask

  logic [W-1:0] l0, l1;

  initial begin
    bus.thresh = '0; bus.thresh_wr = '0; bus.thresh_update = '0;

    // Reset
    step(1'b0, 2'b00, 2'b00, '0, 1'b0);
    step(1'b0, 2'b00, 2'b00, '0, 1'b0);
    idle(2);
    chk("rst_trig_const",  trig46,  {NB{18'h3FFFF}});
    chk("rst_delta_const", delta46, '0);

    // Directed full load with known values
    for (int k = ND - 1; k >= 0; k--) begin
      l0 = W'(32'h100 * k + 1);
      l1 = W'(32'h100 * k + 1 + 32'h80);
      step(1'b1, 2'b11, 2'b00, {l1, l0}, 1'b0);
      l0 = W'(32'h100 * k);
      l1 = W'(32'h100 * k + 32'h80);
      step(1'b1, 2'b11, 2'b00, {l1, l0}, 1'b0);
    end
    update();
    chk("b10_trig_const",  trig46[10*W +: W],  18'h500);
    chk("b10_delta_const", delta46[10*W +: W], 18'h501);
    chk("b11_trig_const",  trig46[11*W +: W],  18'h580);
    chk("b44_trig45_const", trig45[44*W +: W], 18'h1600);
    chk("commit_pulse_const", commit46, 1'b1);
    idle(1);
    chk("commit_drop_const", commit46, 1'b0);

    // Short load rejected, then cleared
    rand_writes(45);
    update();
    chk("short_errc_const", errc46, 1'b1);
    step(1'b1, 2'b00, 2'b00, '0, 1'b1);
    idle(1);

    // Overfull rejected, then a clean load commits
    rand_writes(47);
    update();
    rand_writes(46);
    update();
    step(1'b1, 2'b00, 2'b00, '0, 1'b1);

    // Lane mismatch, then write coincident with update
    step(1'b1, 2'b01, 2'b00, {W'($urandom), W'($urandom)}, 1'b0);
    idle(1);
    step(1'b1, 2'b00, 2'b00, '0, 1'b1);
    rand_writes(46);
    step(1'b1, 2'b11, 2'b11, {W'($urandom), W'($urandom)}, 1'b0);
    // Clear racing a new error: error wins
    step(1'b1, 2'b10, 2'b00, {W'($urandom), W'($urandom)}, 1'b1);
    step(1'b1, 2'b00, 2'b00, '0, 1'b1);

    // Reset mid-load, then clean load
    rand_writes(20);
    step(1'b0, 2'b11, 2'b00, {W'($urandom), W'($urandom)}, 1'b0);
    rand_writes(46);
    update();
    // Recommit without new writes is rejected
    update();
    // Reset in the commit cycle: reset wins
    rand_writes(46);
    step(1'b0, 2'b00, 2'b11, '0, 1'b0);
    idle(1);

    // Randomized loads
    for (int it = 0; it < 40; it++) begin
      int n;
      n = (($urandom % 4) == 0) ? int'($urandom_range(44, 48)) : DEPTH;
      for (int i = 0; i < n; i++) begin
        logic [1:0] wr;
        wr = (($urandom % 25) == 0) ? 2'($urandom) : 2'b11;
        if (wr[0] == 1'b0 && wr[1] == 1'b0) wr = 2'b11;
        step(1'b1, wr, 2'b00, {W'($urandom), W'($urandom)}, (($urandom % 30) == 0));
        if (($urandom % 10) == 0) idle(1);
      end
      if (($urandom % 12) == 0) step(1'b1, 2'b00, 2'b01, '0, 1'b0);
      else                      update();
      if (($urandom % 8) == 0) step(1'b1, 2'b00, 2'b00, '0, 1'b1);
      if (($urandom % 15) == 0) step(1'b0, 2'b00, 2'b00, '0, 1'b0);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
